// File: rtl/adc_scan_display_if.sv
// Request/ready/valid handshake between the channel scanner and the I2C ADC master.
// master modport: scanner side; slave modport: ADC master side.
interface adc_scan_display_if #(
    parameter int DATA_W = 8
);
    logic              rd_req;
    logic [7:0]        reg_addr;
    logic              reg_addr_vld;
    logic              ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_vld;

    modport master (
        output rd_req, reg_addr, reg_addr_vld,
        input  ready, rd_data, rd_data_vld
    );

    modport slave (
        input  rd_req, reg_addr, reg_addr_vld,
        output ready, rd_data, rd_data_vld
    );
endinterface

// File: rtl/adc_scan_display.sv
// Round-robin multi-channel ADC scanner with double-dabble BCD conversion and 7-seg digit packing.
// Optional 4-sample averaging per channel is enabled by defining ADC_SCAN_AVG_EN.
module adc_scan_display #(
    parameter int         DATA_W    = 8,
    parameter int         CH_NUM    = 4,
    parameter logic [7:0] CTRL_BASE = 8'h40,
    parameter int         SCAN_DIV  = 5_000_000,
    parameter int         TIMEOUT   = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    adc_scan_display_if.master  adc,
    output logic [31:0]         dsp_data,
    output logic [2:0]          cur_ch,
    output logic                sample_vld,
    output logic                err
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, CONV, PACK, ERR} state_t;

    localparam logic [31:0] SCAN_LAST = 32'(SCAN_DIV - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [4:0]  ITER_LAST = 5'(DATA_W - 1);
    localparam logic [2:0]  CH_LAST   = 3'(CH_NUM - 1);
    localparam logic [31:0] DSP_RESET = {4'd15, 28'hAAAAAAA};

    state_t            state_q;
    logic [31:0]       tick_q;
    logic [31:0]       tmo_q;
    logic [2:0]        ch_q;
    logic [DATA_W-1:0] shift_q;
    logic [19:0]       bcd_q;
    logic [4:0]        iter_q;
    logic              rd_req_q;
    logic [7:0]        addr_q;
    logic              addr_vld_q;
    logic [31:0]       dsp_q;
    logic [2:0]        cur_ch_q;
    logic              sample_vld_q;
    logic              err_q;

`ifdef ADC_SCAN_AVG_EN
    logic [DATA_W+1:0] acc_q;
    logic [1:0]        nsamp_q;
    logic [DATA_W+1:0] acc_d;
`endif

    logic [19:0] bcd_adj;
    logic [19:0] bcd_d;
    logic [19:0] digits;
    logic        lead;
    logic [2:0]  ch_d;

    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[18:0], shift_q[DATA_W-1]};

        // Blank leading zeros; digit 0 is always shown so a zero value reads "0".
        digits = bcd_q;
        lead   = 1'b1;
        for (int unsigned i = 4; i > 0; i--) begin
            if (lead && (bcd_q[4*i +: 4] == 4'd0))
                digits[4*i +: 4] = 4'd10;
            else
                lead = 1'b0;
        end

        ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 3'd1;
`ifdef ADC_SCAN_AVG_EN
        acc_d = acc_q + {2'b00, adc.rd_data};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            tick_q       <= '0;
            tmo_q        <= '0;
            ch_q         <= '0;
            shift_q      <= '0;
            bcd_q        <= '0;
            iter_q       <= '0;
            rd_req_q     <= 1'b0;
            addr_q       <= CTRL_BASE;
            addr_vld_q   <= 1'b0;
            dsp_q        <= DSP_RESET;
            cur_ch_q     <= '0;
            sample_vld_q <= 1'b0;
            err_q        <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
            acc_q        <= '0;
            nsamp_q      <= '0;
`endif
        end else begin
            rd_req_q     <= 1'b0;
            addr_vld_q   <= 1'b0;
            sample_vld_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick_q == SCAN_LAST) begin
                        tick_q  <= '0;
                        addr_q  <= CTRL_BASE | {5'b0, ch_q};
                        state_q <= REQ;
                    end else begin
                        tick_q <= tick_q + 32'd1;
                    end
                end
                REQ: begin
                    if (adc.ready) begin
                        rd_req_q   <= 1'b1;
                        addr_vld_q <= 1'b1;
                        tmo_q      <= '0;
                        state_q    <= WAIT;
                    end
                end
                WAIT: begin
                    if (adc.rd_data_vld) begin
`ifdef ADC_SCAN_AVG_EN
                        // Fourth sample feeds the converter; earlier ones re-request immediately.
                        if (nsamp_q == 2'd3) begin
                            shift_q <= acc_d[DATA_W+1:2];
                            bcd_q   <= '0;
                            iter_q  <= '0;
                            acc_q   <= '0;
                            nsamp_q <= '0;
                            state_q <= CONV;
                        end else begin
                            acc_q   <= acc_d;
                            nsamp_q <= nsamp_q + 2'd1;
                            state_q <= REQ;
                        end
`else
                        shift_q <= adc.rd_data;
                        bcd_q   <= '0;
                        iter_q  <= '0;
                        state_q <= CONV;
`endif
                    end else if (tmo_q == TMO_LAST) begin
`ifdef ADC_SCAN_AVG_EN
                        acc_q   <= '0;
                        nsamp_q <= '0;
`endif
                        state_q <= ERR;
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                CONV: begin
                    bcd_q   <= bcd_d;
                    shift_q <= {shift_q[DATA_W-2:0], 1'b0};
                    iter_q  <= iter_q + 5'd1;
                    if (iter_q == ITER_LAST)
                        state_q <= PACK;
                end
                PACK: begin
                    dsp_q        <= {1'b0, ch_q, 4'd10, 4'd10, digits};
                    sample_vld_q <= 1'b1;
                    cur_ch_q     <= ch_q;
                    err_q        <= 1'b0;
                    ch_q         <= ch_d;
                    tick_q       <= '0;
                    state_q      <= IDLE;
                end
                ERR: begin
                    dsp_q    <= {1'b0, ch_q, 4'd10, 4'd10, 4'd14, 16'hAAAA};
                    err_q    <= 1'b1;
                    cur_ch_q <= ch_q;
                    ch_q     <= ch_d;
                    tick_q   <= '0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign adc.rd_req       = rd_req_q;
    assign adc.reg_addr     = addr_q;
    assign adc.reg_addr_vld = addr_vld_q;
    assign dsp_data         = dsp_q;
    assign cur_ch           = cur_ch_q;
    assign sample_vld       = sample_vld_q;
    assign err              = err_q;

endmodule

// File: tb/tb_adc_scan_display.sv
// Directed bench for adc_scan_display: a 4-channel 8-bit instance and a 1-channel 16-bit instance.
// Averaging expectations switch with ADC_SCAN_AVG_EN.
module tb_adc_scan_display;

`ifdef ADC_SCAN_AVG_EN
    localparam int NSAMP = 4;
`else
    localparam int NSAMP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    adc_scan_display_if #(.DATA_W(8))  bus0 ();
    adc_scan_display_if #(.DATA_W(16)) bus1 ();

    logic [31:0] dsp0, dsp1;
    logic [2:0]  ch0, ch1;
    logic        sv0, sv1, err0, err1;

    adc_scan_display #(.DATA_W(8), .CH_NUM(4), .CTRL_BASE(8'h40), .SCAN_DIV(16), .TIMEOUT(32)) dut0 (
        .clk(clk), .rst(rst), .adc(bus0),
        .dsp_data(dsp0), .cur_ch(ch0), .sample_vld(sv0), .err(err0)
    );

    adc_scan_display #(.DATA_W(16), .CH_NUM(1), .CTRL_BASE(8'h40), .SCAN_DIV(16), .TIMEOUT(32)) dut1 (
        .clk(clk), .rst(rst), .adc(bus1),
        .dsp_data(dsp1), .cur_ch(ch1), .sample_vld(sv1), .err(err1)
    );

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Wait (bounded) for a request on bus0, then answer it two cycles later.
    task automatic serve0(input logic [7:0] val, output bit ok, output logic [7:0] addr, output logic avld);
        ok = 1'b0; addr = '0; avld = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus0.rd_req) begin
                ok = 1'b1; addr = bus0.reg_addr; avld = bus0.reg_addr_vld;
            end
        end
        if (ok) begin
            repeat (2) @(posedge clk);
            #1 bus0.rd_data = val; bus0.rd_data_vld = 1'b1;
            @(posedge clk);
            #1 bus0.rd_data_vld = 1'b0;
        end
    endtask

    task automatic serve1(input logic [15:0] val, output bit ok, output logic [7:0] addr);
        ok = 1'b0; addr = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus1.rd_req) begin
                ok = 1'b1; addr = bus1.reg_addr;
            end
        end
        if (ok) begin
            repeat (2) @(posedge clk);
            #1 bus1.rd_data = val; bus1.rd_data_vld = 1'b1;
            @(posedge clk);
            #1 bus1.rd_data_vld = 1'b0;
        end
    endtask

    task automatic wait_sv0(output bit ok, output int n);
        ok = 1'b0; n = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            n++;
            if (sv0) ok = 1'b1;
        end
    endtask

    task automatic wait_sv1(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clk); #1;
            if (sv1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus0.ready = 1'b1; bus0.rd_data = '0; bus0.rd_data_vld = 1'b0;
        bus1.ready = 1'b0; bus1.rd_data = '0; bus1.rd_data_vld = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dsp0 !== 32'hFAAAAAAA) begin errors++; $display("FAIL reset_dsp: got %h expected %h", dsp0, 32'hFAAAAAAA); end
        checks++;
        if ({ch0, bus0.rd_req, bus0.reg_addr_vld, sv0, err0} !== 7'd0)
            begin errors++; $display("FAIL reset_ctl: got ch=%0d req=%b avld=%b sv=%b err=%b expected all 0", ch0, bus0.rd_req, bus0.reg_addr_vld, sv0, err0); end
        checks++;
        if (bus0.reg_addr !== 8'h40) begin errors++; $display("FAIL reset_addr: got %h expected 40", bus0.reg_addr); end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_scan();
        logic [7:0]  vals [4] = '{8'd7, 8'd42, 8'd255, 8'd0};
        logic [31:0] exps [4] = '{32'h0AAAAAA7, 32'h1AAAAA42, 32'h2AAAA255, 32'h3AAAAAA0};
        bit ok; int n; logic [7:0] a; logic av; logic [7:0] ea;
        for (int i = 0; i < 4; i++) begin
            ea = 8'h40 + 8'(i);
            for (int k = 0; k < NSAMP; k++) begin
                serve0(vals[i], ok, a, av);
                checks++;
                if (!ok || a !== ea || av !== 1'b1)
                    begin errors++; $display("FAIL scan_req ch%0d: got ok=%b addr=%h avld=%b expected ok=1 addr=%h avld=1", i, ok, a, av, ea); end
            end
            wait_sv0(ok, n);
            checks++;
            if (!ok || dsp0 !== exps[i] || ch0 !== 3'(i))
                begin errors++; $display("FAIL scan_dsp ch%0d: got ok=%b dsp=%h cur_ch=%0d expected dsp=%h cur_ch=%0d", i, ok, dsp0, ch0, exps[i], i); end
            @(posedge clk); #1;
            checks++;
            if (sv0 !== 1'b0) begin errors++; $display("FAIL scan_pulse ch%0d: sample_vld got %b expected 0", i, sv0); end
        end
    endtask

    task automatic test_latency();
        bit ok; int n; logic [7:0] a; logic av;
        for (int k = 0; k < NSAMP; k++) serve0(8'd5, ok, a, av);
        wait_sv0(ok, n);
        checks++;
        if (!ok || (n + 1) != 10) begin errors++; $display("FAIL latency: got %0d cycles expected 10", n + 1); end
        checks++;
        if (dsp0 !== 32'h0AAAAAA5 || a !== 8'h40) begin errors++; $display("FAIL latency_dsp: got %h addr %h expected 0AAAAAA5 addr 40", dsp0, a); end
    endtask

    task automatic test_timeout();
        bit ok = 1'b0; bit saw_sv = 1'b0; int n = 0; logic [7:0] a = '0; logic av;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(posedge clk); #1;
            if (bus0.rd_req) begin ok = 1'b1; a = bus0.reg_addr; end
        end
        checks++;
        if (!ok || a !== 8'h41) begin errors++; $display("FAIL tmo_req: got ok=%b addr=%h expected ok=1 addr=41", ok, a); end
        while (n < 60 && err0 !== 1'b1) begin
            @(posedge clk); #1;
            n++;
            if (sv0) saw_sv = 1'b1;
            if (n == 30 && err0 !== 1'b0) begin checks++; errors++; $display("FAIL tmo_early: err got 1 at cycle 30 expected 0"); end
        end
        checks++;
        if (n < 32 || n > 34) begin errors++; $display("FAIL tmo_cycles: got %0d expected 32..34", n); end
        checks++;
        if (dsp0 !== 32'h1AAEAAAA || ch0 !== 3'd1 || saw_sv)
            begin errors++; $display("FAIL tmo_dsp: got dsp=%h cur_ch=%0d sv_seen=%b expected 1AAEAAAA 1 0", dsp0, ch0, saw_sv); end
        // Stray strobe while idle must not be captured
        #1 bus0.rd_data = 8'd99; bus0.rd_data_vld = 1'b1;
        @(posedge clk); #1 bus0.rd_data_vld = 1'b0;
        for (int k = 0; k < NSAMP; k++) begin
            serve0(8'd3, ok, a, av);
            checks++;
            if (!ok || a !== 8'h42) begin errors++; $display("FAIL tmo_next_req: got ok=%b addr=%h expected addr 42", ok, a); end
        end
        wait_sv0(ok, n);
        checks++;
        if (!ok || dsp0 !== 32'h2AAAAAA3 || err0 !== 1'b0)
            begin errors++; $display("FAIL tmo_clear: got dsp=%h err=%b expected 2AAAAAA3 err=0", dsp0, err0); end
    endtask

    task automatic test_stall();
        bit ok; bit saw = 1'b0; int n; logic [7:0] a; logic av;
        bus0.ready = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (bus0.rd_req) saw = 1'b1;
        end
        checks++;
        if (saw) begin errors++; $display("FAIL stall_req: rd_req got 1 while ready=0 expected 0"); end
        bus0.ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus0.rd_req !== 1'b1 || bus0.reg_addr !== 8'h43)
            begin errors++; $display("FAIL stall_accept: got req=%b addr=%h expected 1 43", bus0.rd_req, bus0.reg_addr); end
        @(posedge clk); #1;
        checks++;
        if (bus0.rd_req !== 1'b0 || err0 !== 1'b0) begin errors++; $display("FAIL stall_pulse: got req=%b err=%b expected 0 0", bus0.rd_req, err0); end
        bus0.rd_data = 8'd128; bus0.rd_data_vld = 1'b1;
        @(posedge clk); #1 bus0.rd_data_vld = 1'b0;
        for (int k = 1; k < NSAMP; k++) serve0(8'd128, ok, a, av);
        wait_sv0(ok, n);
        checks++;
        if (!ok || dsp0 !== 32'h3AAAA128) begin errors++; $display("FAIL stall_dsp: got %h expected 3AAAA128", dsp0); end
    endtask

    task automatic test_max_single_ch();
        bit ok; logic [7:0] a;
        bus1.ready = 1'b1;
        for (int k = 0; k < NSAMP; k++) serve1(16'd65535, ok, a);
        checks++;
        if (!ok || a !== 8'h40) begin errors++; $display("FAIL max_req: got ok=%b addr=%h expected addr 40", ok, a); end
        wait_sv1(ok);
        checks++;
        if (!ok || dsp1 !== 32'h0AA65535 || ch1 !== 3'd0 || err1 !== 1'b0)
            begin errors++; $display("FAIL max_dsp: got dsp=%h cur_ch=%0d err=%b expected 0AA65535 0 0", dsp1, ch1, err1); end
        for (int k = 0; k < NSAMP; k++) serve1(16'd0, ok, a);
        checks++;
        if (!ok || a !== 8'h40) begin errors++; $display("FAIL single_ch_wrap: got ok=%b addr=%h expected addr 40", ok, a); end
        wait_sv1(ok);
        checks++;
        if (!ok || dsp1 !== 32'h0AAAAAA0 || ch1 !== 3'd0)
            begin errors++; $display("FAIL zero_dsp: got dsp=%h cur_ch=%0d expected 0AAAAAA0 0", dsp1, ch1); end
        bus1.ready = 1'b0;
    endtask

`ifdef ADC_SCAN_AVG_EN
    task automatic test_avg();
        logic [7:0] vals [4] = '{8'd10, 8'd11, 8'd12, 8'd13};
        bit ok; int n; logic [7:0] a; logic av;
        @(negedge clk) rst = 1'b0;
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 4; k++) serve0(vals[k], ok, a, av);
        wait_sv0(ok, n);
        checks++;
        if (!ok || dsp0 !== 32'h0AAAAA11) begin errors++; $display("FAIL avg_dsp: got %h expected 0AAAAA11", dsp0); end
    endtask
`endif

    task automatic test_reset_mid_conv();
        bit ok; int n; logic [7:0] a; logic av;
        for (int k = 0; k < NSAMP; k++) serve0(8'd200, ok, a, av);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (dsp0 !== 32'hFAAAAAAA || sv0 !== 1'b0 || ch0 !== 3'd0 || err0 !== 1'b0 || bus0.reg_addr !== 8'h40)
            begin errors++; $display("FAIL midconv_reset: got dsp=%h sv=%b ch=%0d err=%b addr=%h expected FAAAAAAA 0 0 0 40", dsp0, sv0, ch0, err0, bus0.reg_addr); end
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < NSAMP; k++) serve0(8'd77, ok, a, av);
        checks++;
        if (!ok || a !== 8'h40) begin errors++; $display("FAIL midconv_restart: got ok=%b addr=%h expected addr 40", ok, a); end
        wait_sv0(ok, n);
        checks++;
        if (!ok || dsp0 !== 32'h0AAAAA77) begin errors++; $display("FAIL midconv_next: got %h expected 0AAAAA77", dsp0); end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_latency();
        test_timeout();
        test_stall();
        test_max_single_ch();
`ifdef ADC_SCAN_AVG_EN
        test_avg();
`endif
        test_reset_mid_conv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
